// File: rtl/service_job_executor.sv
// Executes a latched 6-bit car-service order: runs each selected service in turn,
// counting its duration in time units and billing its cost on completion.
module service_job_executor #(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] sel,
  input  logic       abort,
  output logic       busy,
  output logic [2:0] cur_svc,
  output logic       svc_done,
  output logic       done,
  output logic       aborted,
  output logic [4:0] elapsed,
  output logic [6:0] billed
);

  // state  | meaning
  // S_IDLE | waiting for start; totals hold the last job's values
  // S_SCAN | examining job bit idx, one index per cycle
  // S_RUN  | counting down the selected service's time units
  // S_DONE | one-cycle done pulse, then back to idle
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RUN, S_DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);

  state_t     state_q, state_d;
  logic [5:0] job_q, job_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] div_q, div_d;
  logic [2:0] rem_q, rem_d;
  logic [4:0] elapsed_q, elapsed_d;
  logic [6:0] billed_q, billed_d;
  logic       busy_q, busy_d;
  logic       svc_done_q, svc_done_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;

  function automatic logic [2:0] svc_time(input logic [2:0] i);
    case (i)
      3'd0, 3'd1: return 3'd5;
      3'd2, 3'd3: return 3'd7;
      default:    return 3'd3;
    endcase
  endfunction

  function automatic logic [6:0] svc_cost(input logic [2:0] i);
    case (i)
      3'd0, 3'd1: return 7'd20;
      3'd2, 3'd3: return 7'd30;
      default:    return 7'd10;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    job_d      = job_q;
    idx_d      = idx_q;
    div_d      = div_q;
    rem_d      = rem_q;
    elapsed_d  = elapsed_q;
    billed_d   = billed_q;
    svc_done_d = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          job_d     = sel;
          elapsed_d = 5'd0;
          billed_d  = 7'd0;
          idx_d     = 3'd0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (idx_q == 3'd6) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (job_q[idx_q]) begin
          rem_d   = svc_time(idx_q);
          // divider is a down-counter; starting at its top gives TICK_DIV cycles per unit
          div_d   = DIV_LAST;
          state_d = S_RUN;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (div_q == 8'd0) begin
          div_d     = DIV_LAST;
          rem_d     = rem_q - 3'd1;
          elapsed_d = elapsed_q + 5'd1;
          if (rem_q == 3'd1) begin
            billed_d   = billed_q + svc_cost(idx_q);
            svc_done_d = 1'b1;
            idx_d      = idx_q + 3'd1;
            state_d    = S_SCAN;
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      job_q      <= 6'd0;
      idx_q      <= 3'd0;
      div_q      <= 8'd0;
      rem_q      <= 3'd0;
      elapsed_q  <= 5'd0;
      billed_q   <= 7'd0;
      busy_q     <= 1'b0;
      svc_done_q <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      job_q      <= job_d;
      idx_q      <= idx_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      elapsed_q  <= elapsed_d;
      billed_q   <= billed_d;
      busy_q     <= busy_d;
      svc_done_q <= svc_done_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign busy     = busy_q;
  assign cur_svc  = idx_q;
  assign svc_done = svc_done_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign elapsed  = elapsed_q;
  assign billed   = billed_q;

endmodule
